// File: rtl/tff_pkg.sv
// Shared types and default timing constants for the toggle-request front end.
package tff_pkg;

   // Debounce / auto-repeat controller states.
   typedef enum logic [2:0] {
      IDLE       = 3'd0,
      DB_PRESS   = 3'd1,
      HELD       = 3'd2,
      REPEAT     = 3'd3,
      DB_RELEASE = 3'd4
   } tff_state_e;

   // Default timing, in clk cycles.
   localparam int DB_CYCLES_DEF     = 16;
   localparam int HOLD_CYCLES_DEF   = 64;
   localparam int REPEAT_CYCLES_DEF = 16;

   // Largest of three values; used to size the shared counter.
   function automatic int max3(input int a, input int b, input int c);
      int m;
      m = a;
      if (b > m) m = b;
      if (c > m) m = c;
      return m;
   endfunction

endpackage

// File: rtl/sync2.sv
// Two-flop synchronizer for a single asynchronous bit, synchronous active-low reset.
module sync2 (
   input  logic clk,
   input  logic reset_n,
   input  logic d,
   output logic q
);

   logic meta_q, meta_d;
   logic sync_q, sync_d;

   // Shift the raw bit through the two-stage chain.
   always_comb begin
      meta_d = d;
      sync_d = meta_q;
   end

   // Synchronizer flops; both stages clear on reset.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         meta_q <= 1'b0;
         sync_q <= 1'b0;
      end else begin
         meta_q <= meta_d;
         sync_q <= sync_d;
      end
   end

   // Only the second stage is visible downstream.
   always_comb q = sync_q;

endmodule

// File: rtl/tff_toggle_req.sv
// Turns a bouncy asynchronous button into clean one-cycle toggle requests for a
// downstream TFF: synchronize, debounce press and release, one-shot on accepted
// press, optional auto-repeat while held.
//
// Timing bounds: DB_CYCLES >= 2, HOLD_CYCLES >= 1, REPEAT_CYCLES >= 2.
// The counter never wraps; it saturates at all-ones, which is how a hold with
// auto-repeat disabled (or cancelled) is kept from ever pulsing again.
module tff_toggle_req
   import tff_pkg::*;
#(
   parameter int DB_CYCLES     = DB_CYCLES_DEF,
   parameter int HOLD_CYCLES   = HOLD_CYCLES_DEF,
   parameter int REPEAT_CYCLES = REPEAT_CYCLES_DEF
) (
   input  logic clk,
   input  logic reset_n,
   input  logic btn_raw,
   input  logic rpt_en,
   output logic t_pulse,
   output logic btn_state,
   output logic busy
);

   localparam int CNT_W = $clog2(max3(DB_CYCLES, HOLD_CYCLES, REPEAT_CYCLES)) + 1;

   localparam logic [CNT_W-1:0] CNT_ZERO  = '0;
   localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_MAX   = '1;
   localparam logic [CNT_W-1:0] DB_LAST   = CNT_W'(DB_CYCLES - 1);
   localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
   localparam logic [CNT_W-1:0] RPT_LAST  = CNT_W'(REPEAT_CYCLES - 1);

   logic             btn_sync;
   tff_state_e       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [CNT_W-1:0] cnt_inc;
   logic             t_pulse_q, t_pulse_d;
   logic             btn_state_q, btn_state_d;

   sync2 u_sync2 (
      .clk     (clk),
      .reset_n (reset_n),
      .d       (btn_raw),
      .q       (btn_sync)
   );

   // State register: FSM, shared counter and registered outputs.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q     <= IDLE;
         cnt_q       <= CNT_ZERO;
         t_pulse_q   <= 1'b0;
         btn_state_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         t_pulse_q   <= t_pulse_d;
         btn_state_q <= btn_state_d;
      end
   end

   // Next state: a btn_sync change always outranks a terminal count.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      t_pulse_d   = 1'b0;
      btn_state_d = btn_state_q;
      cnt_inc     = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_ONE;
      case (state_q)
         IDLE: begin
            if (btn_sync) begin
               state_d = DB_PRESS;
               cnt_d   = CNT_ONE;
            end else begin
               cnt_d   = CNT_ZERO;
            end
         end
         DB_PRESS: begin
            if (!btn_sync) begin
               state_d = IDLE;
               cnt_d   = CNT_ZERO;
            end else if (cnt_q == DB_LAST) begin
               state_d     = HELD;
               cnt_d       = CNT_ZERO;
               t_pulse_d   = 1'b1;
               btn_state_d = 1'b1;
            end else begin
               cnt_d = cnt_inc;
            end
         end
         HELD: begin
            if (!btn_sync) begin
               state_d = DB_RELEASE;
               cnt_d   = CNT_ONE;
            end else if (rpt_en && (cnt_q == HOLD_LAST)) begin
               state_d   = REPEAT;
               cnt_d     = CNT_ZERO;
               t_pulse_d = 1'b1;
            end else begin
               cnt_d = cnt_inc;
            end
         end
         REPEAT: begin
            if (!btn_sync) begin
               state_d = DB_RELEASE;
               cnt_d   = CNT_ONE;
            end else if (!rpt_en) begin
               // Cancelled repeat parks in HELD with a counter that can never match.
               state_d = HELD;
               cnt_d   = CNT_MAX;
            end else if (cnt_q == RPT_LAST) begin
               cnt_d     = CNT_ZERO;
               t_pulse_d = 1'b1;
            end else begin
               cnt_d = cnt_inc;
            end
         end
         DB_RELEASE: begin
            if (btn_sync) begin
               // Release bounce: back to HELD silently, no re-toggle.
               state_d = HELD;
               cnt_d   = CNT_ZERO;
            end else if (cnt_q == DB_LAST) begin
               state_d     = IDLE;
               cnt_d       = CNT_ZERO;
               btn_state_d = 1'b0;
            end else begin
               cnt_d = cnt_inc;
            end
         end
         default: begin
            state_d     = IDLE;
            cnt_d       = CNT_ZERO;
            btn_state_d = 1'b0;
         end
      endcase
   end

   // Outputs: pulse and level come straight from flops; busy decodes the state.
   always_comb begin
      t_pulse   = t_pulse_q;
      btn_state = btn_state_q;
      busy      = (state_q != IDLE);
   end

endmodule

// File: tb/tb_tff_toggle_req.sv
// Directed bench for tff_toggle_req with DB=4, HOLD=10, REPEAT=3 and a
// behavioural downstream TFF. Edge numbering: inputs are driven 1 time unit
// after edge 0; edge n is the n-th rising edge after that, and outputs are
// sampled 1 time unit after it.
module tb_tff_toggle_req;

   localparam int DB  = 4;
   localparam int HLD = 10;
   localparam int RPT = 3;

   logic clk;
   logic reset_n;
   logic btn_raw;
   logic rpt_en;
   logic t_pulse;
   logic btn_state;
   logic busy;
   logic tff_q;

   int n_checks;
   int n_fail;

   logic [7:0] exp_q[$];

   tff_toggle_req #(
      .DB_CYCLES     (DB),
      .HOLD_CYCLES   (HLD),
      .REPEAT_CYCLES (RPT)
   ) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .btn_raw   (btn_raw),
      .rpt_en    (rpt_en),
      .t_pulse   (t_pulse),
      .btn_state (btn_state),
      .busy      (busy)
   );

   // Clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Downstream toggle flip-flop fed by t_pulse
   always_ff @(posedge clk) begin
      if (!reset_n) tff_q <= 1'b0;
      else if (t_pulse) tff_q <= ~tff_q;
   end

   // Safety net against a stuck run
   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic apply_reset(input logic rpt);
      reset_n = 1'b0;
      btn_raw = 1'b0;
      rpt_en  = rpt;
      step();
      step();
      reset_n = 1'b1;
      step();
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      btn_raw = 1'b1;
      rpt_en  = 1'b1;
      step(); step(); step();
      n_checks++; if (t_pulse !== 1'b0)   begin n_fail++; $display("FAIL reset_t_pulse: got %b want 0", t_pulse); end
      n_checks++; if (btn_state !== 1'b0) begin n_fail++; $display("FAIL reset_btn_state: got %b want 0", btn_state); end
      n_checks++; if (busy !== 1'b0)      begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
      n_checks++; if (tff_q !== 1'b0)     begin n_fail++; $display("FAIL reset_tff_q: got %b want 0", tff_q); end
   endtask

   task automatic test_clean_press();
      logic exp_p;
      apply_reset(1'b0);
      btn_raw = 1'b1;
      for (int n = 1; n <= 30; n++) begin
         step();
         exp_p = (n == DB + 2);
         n_checks++; if (t_pulse !== exp_p) begin n_fail++; $display("FAIL press_t_pulse edge %0d: got %b want %b", n, t_pulse, exp_p); end
         n_checks++; if (busy !== (n >= 3)) begin n_fail++; $display("FAIL press_busy edge %0d: got %b want %b", n, busy, (n >= 3)); end
         n_checks++; if (btn_state !== (n >= DB + 2)) begin n_fail++; $display("FAIL press_btn_state edge %0d: got %b want %b", n, btn_state, (n >= DB + 2)); end
      end
      n_checks++; if (tff_q !== 1'b1) begin n_fail++; $display("FAIL press_tff_q: got %b want 1", tff_q); end
      btn_raw = 1'b0;
      for (int n = 1; n <= 10; n++) step();
      n_checks++; if (btn_state !== 1'b0) begin n_fail++; $display("FAIL press_release_btn_state: got %b want 0", btn_state); end
      n_checks++; if (busy !== 1'b0)      begin n_fail++; $display("FAIL press_release_busy: got %b want 0", busy); end
      n_checks++; if (tff_q !== 1'b1)     begin n_fail++; $display("FAIL press_release_tff_q: got %b want 1", tff_q); end
   endtask

   task automatic test_bounce();
      logic exp_busy;
      apply_reset(1'b0);
      // raw sampled high at edges 1,2,4,5 only
      btn_raw = 1'b1;
      for (int n = 1; n <= 15; n++) begin
         step();
         btn_raw = ((n + 1) == 2) || ((n + 1) == 4) || ((n + 1) == 5);
         exp_busy = (n == 3) || (n == 4) || (n == 6) || (n == 7);
         n_checks++; if (t_pulse !== 1'b0)   begin n_fail++; $display("FAIL bounce_t_pulse edge %0d: got %b want 0", n, t_pulse); end
         n_checks++; if (busy !== exp_busy) begin n_fail++; $display("FAIL bounce_busy edge %0d: got %b want %b", n, busy, exp_busy); end
      end
      n_checks++; if (btn_state !== 1'b0) begin n_fail++; $display("FAIL bounce_btn_state: got %b want 0", btn_state); end
      n_checks++; if (tff_q !== 1'b0)     begin n_fail++; $display("FAIL bounce_tff_q: got %b want 0", tff_q); end
   endtask

   task automatic test_auto_repeat();
      logic exp_p;
      logic prev_p;
      logic exp_tff;
      apply_reset(1'b1);
      exp_q = {8'd6, 8'd16, 8'd19, 8'd22, 8'd25, 8'd28};
      exp_tff = 1'b0;
      prev_p  = 1'b0;
      btn_raw = 1'b1;
      for (int n = 1; n <= 36; n++) begin
         step();
         // Raw high for 28 samples; the drop reaches the FSM at edge 31,
         // the same edge as the next repeat terminal count, and must win.
         if (n == 28) btn_raw = 1'b0;
         if (prev_p) exp_tff = ~exp_tff;
         exp_p = (exp_q.size() != 0) && (exp_q[0] == 8'(n));
         n_checks++; if (t_pulse !== exp_p)  begin n_fail++; $display("FAIL repeat_t_pulse edge %0d: got %b want %b", n, t_pulse, exp_p); end
         n_checks++; if (tff_q !== exp_tff)  begin n_fail++; $display("FAIL repeat_tff_q edge %0d: got %b want %b", n, tff_q, exp_tff); end
         n_checks++; if (btn_state !== ((n >= 6) && (n < 34))) begin n_fail++; $display("FAIL repeat_btn_state edge %0d: got %b want %b", n, btn_state, ((n >= 6) && (n < 34))); end
         if (exp_p) void'(exp_q.pop_front());
         prev_p = exp_p;
      end
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL repeat_busy_end: got %b want 0", busy); end
      rpt_en = 1'b0;
   endtask

   task automatic test_release_bounce();
      apply_reset(1'b0);
      btn_raw = 1'b1;
      for (int n = 1; n <= 12; n++) step();
      n_checks++; if (btn_state !== 1'b1) begin n_fail++; $display("FAIL relb_accept_btn_state: got %b want 1", btn_state); end
      // Low at sample 13, one-sample glitch high at 14, low from 15 on.
      btn_raw = 1'b0;
      for (int m = 1; m <= 12; m++) begin
         step();
         btn_raw = (m == 1);
         n_checks++; if (t_pulse !== 1'b0)        begin n_fail++; $display("FAIL relb_t_pulse +%0d: got %b want 0", m, t_pulse); end
         n_checks++; if (btn_state !== (m < 8))  begin n_fail++; $display("FAIL relb_btn_state +%0d: got %b want %b", m, btn_state, (m < 8)); end
         n_checks++; if (busy !== (m < 8))       begin n_fail++; $display("FAIL relb_busy +%0d: got %b want %b", m, busy, (m < 8)); end
      end
      n_checks++; if (tff_q !== 1'b1) begin n_fail++; $display("FAIL relb_tff_q: got %b want 1", tff_q); end
   endtask

   task automatic test_reset_mid_debounce();
      apply_reset(1'b0);
      btn_raw = 1'b1;
      for (int n = 1; n <= 5; n++) begin
         step();
         n_checks++; if (t_pulse !== 1'b0) begin n_fail++; $display("FAIL rstdb_pre_t_pulse edge %0d: got %b want 0", n, t_pulse); end
      end
      // Counter is at DB-1 here; reset lands on the edge that would accept.
      reset_n = 1'b0;
      step();
      n_checks++; if (t_pulse !== 1'b0)   begin n_fail++; $display("FAIL rstdb_t_pulse: got %b want 0", t_pulse); end
      n_checks++; if (btn_state !== 1'b0) begin n_fail++; $display("FAIL rstdb_btn_state: got %b want 0", btn_state); end
      n_checks++; if (busy !== 1'b0)      begin n_fail++; $display("FAIL rstdb_busy: got %b want 0", busy); end
      reset_n = 1'b1;
      for (int n = 7; n <= 14; n++) begin
         step();
         n_checks++; if (t_pulse !== (n == 12))   begin n_fail++; $display("FAIL rstdb_post_t_pulse edge %0d: got %b want %b", n, t_pulse, (n == 12)); end
         n_checks++; if (btn_state !== (n >= 12)) begin n_fail++; $display("FAIL rstdb_post_btn_state edge %0d: got %b want %b", n, btn_state, (n >= 12)); end
      end
      n_checks++; if (tff_q !== 1'b1) begin n_fail++; $display("FAIL rstdb_tff_q: got %b want 1", tff_q); end
   endtask

   task automatic test_reset_in_repeat();
      apply_reset(1'b1);
      btn_raw = 1'b1;
      for (int n = 1; n <= 21; n++) step();
      n_checks++; if (busy !== 1'b1)  begin n_fail++; $display("FAIL rstrp_pre_busy: got %b want 1", busy); end
      n_checks++; if (tff_q !== 1'b1) begin n_fail++; $display("FAIL rstrp_pre_tff_q: got %b want 1", tff_q); end
      // Edge 22 would carry a repeat pulse; reset must suppress it.
      reset_n = 1'b0;
      step();
      n_checks++; if (t_pulse !== 1'b0)   begin n_fail++; $display("FAIL rstrp_t_pulse: got %b want 0", t_pulse); end
      n_checks++; if (btn_state !== 1'b0) begin n_fail++; $display("FAIL rstrp_btn_state: got %b want 0", btn_state); end
      n_checks++; if (busy !== 1'b0)      begin n_fail++; $display("FAIL rstrp_busy: got %b want 0", busy); end
      n_checks++; if (tff_q !== 1'b0)     begin n_fail++; $display("FAIL rstrp_tff_q: got %b want 0", tff_q); end
      reset_n = 1'b1;
      btn_raw = 1'b0;
      rpt_en  = 1'b0;
      step(); step();
   endtask

   task automatic test_rpt_stop();
      apply_reset(1'b1);
      btn_raw = 1'b1;
      for (int n = 1; n <= 17; n++) step();
      n_checks++; if (tff_q !== 1'b0) begin n_fail++; $display("FAIL rpts_pre_tff_q: got %b want 0", tff_q); end
      // Cancel repeat while in REPEAT, then re-enable it while still held.
      rpt_en = 1'b0;
      for (int n = 18; n <= 40; n++) begin
         step();
         if (n == 25) rpt_en = 1'b1;
         n_checks++; if (t_pulse !== 1'b0)   begin n_fail++; $display("FAIL rpts_t_pulse edge %0d: got %b want 0", n, t_pulse); end
         n_checks++; if (btn_state !== 1'b1) begin n_fail++; $display("FAIL rpts_btn_state edge %0d: got %b want 1", n, btn_state); end
      end
      n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL rpts_busy: got %b want 1", busy); end
      rpt_en = 1'b0;
   endtask

   initial begin
      n_checks = 0;
      n_fail   = 0;
      reset_n  = 1'b0;
      btn_raw  = 1'b0;
      rpt_en   = 1'b0;
      test_reset();
      test_clean_press();
      test_bounce();
      test_auto_repeat();
      test_release_bounce();
      test_reset_mid_debounce();
      test_reset_in_repeat();
      test_rpt_stop();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
